axi_crossbar_wch_scheduler: RTL

- Per-slave W-channel sequencer for the crossbar slave switch.
- Records the order of AW handshakes (which master won the AW arbiter) in an order FIFO.
- Drives a one-hot W grant that locks onto the head master until its WLAST beat, so W bursts are never interleaved and always follow AW order.
- Replaces free-running per-beat round-robin on the W path; also back-pressures AW when the order FIFO is full.

---
 rtl/axi_crossbar_pkg.sv | 36 +++
 rtl/axi_crossbar_wch_scheduler_if.sv | 27 ++
 rtl/axi_crossbar_order_fifo.sv | 53 +++++
 rtl/axi_crossbar_wch_scheduler.sv | 103 ++++++++++
 4 files changed

// File: rtl/axi_crossbar_pkg.sv
// Shared crossbar definitions: W-scheduler state encoding and
// one-hot/index conversion helpers used by the slave switch.
package axi_crossbar_pkg;

    localparam int unsigned MST_MAX       = 32;
    localparam int unsigned MST_MAX_IDX_W = 5;

    typedef enum logic {
        SCH_IDLE,
        SCH_BURST
    } sch_state_t;

    // Index of the lowest set bit; 0 when the vector is all zero.
    function automatic logic [MST_MAX_IDX_W-1:0] onehot_to_idx(input logic [MST_MAX-1:0] vec);
        logic [MST_MAX_IDX_W-1:0] idx;
        logic                     found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MST_MAX; i++) begin
            if (vec[i] && !found) begin
                idx   = MST_MAX_IDX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic [MST_MAX-1:0] idx_to_onehot(input logic [MST_MAX_IDX_W-1:0] idx);
        return MST_MAX'(1) << idx;
    endfunction

    function automatic logic is_onehot(input logic [MST_MAX-1:0] vec);
        return (vec != '0) && ((vec & (vec - MST_MAX'(1))) == '0);
    endfunction

endpackage

// File: rtl/axi_crossbar_wch_scheduler_if.sv
// Handshake/status bundle between the slave switch and its W-channel scheduler.
interface axi_crossbar_wch_scheduler_if #(
    parameter int unsigned MST_NB       = 3,
    parameter int unsigned FIFO_DEPTH_W = 2,
    parameter int unsigned BEAT_CNT_W   = 8
);
    logic [MST_NB-1:0]       i_aw_grant;
    logic                    i_aw_hs;
    logic                    i_w_hs;
    logic                    i_wlast;
    logic                    o_aw_allow;
    logic [MST_NB-1:0]       o_w_grant;
    logic                    o_w_active;
    logic [BEAT_CNT_W-1:0]   o_beat_cnt;
    logic [FIFO_DEPTH_W:0]   o_outstanding;
    logic                    o_err;

    modport slave (
        input  i_aw_grant, i_aw_hs, i_w_hs, i_wlast,
        output o_aw_allow, o_w_grant, o_w_active, o_beat_cnt, o_outstanding, o_err
    );

    modport master (
        output i_aw_grant, i_aw_hs, i_w_hs, i_wlast,
        input  o_aw_allow, o_w_grant, o_w_active, o_beat_cnt, o_outstanding, o_err
    );
endinterface

// File: rtl/axi_crossbar_order_fifo.sv
// Small synchronous FIFO recording transaction order; extra pointer MSB
// distinguishes full from empty.
module axi_crossbar_order_fifo #(
    parameter int unsigned DATA_W  = 2,
    parameter int unsigned DEPTH_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               push,
    input  logic               pop,
    input  logic [DATA_W-1:0]  din,
    output logic [DATA_W-1:0]  head,
    output logic               full,
    output logic               empty,
    output logic [DEPTH_W:0]   count
);

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_W)-1];
    logic [DEPTH_W:0]  wr_ptr;
    logic [DEPTH_W:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer update; both wrap naturally at 2^(DEPTH_W+1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_W-1:0]] <= din;
    end

    assign head  = mem[rd_ptr[DEPTH_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_W] != rd_ptr[DEPTH_W]) &&
                   (wr_ptr[DEPTH_W-1:0] == rd_ptr[DEPTH_W-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/axi_crossbar_wch_scheduler.sv
// Per-slave W-channel sequencer: queues AW winners in order and locks the
// W grant onto the head master until its WLAST beat.
module axi_crossbar_wch_scheduler
    import axi_crossbar_pkg::*;
#(
    parameter int unsigned MST_NB       = 3,
    parameter int unsigned MST_IDX_W    = 2,
    parameter int unsigned FIFO_DEPTH_W = 2,
    parameter int unsigned BEAT_CNT_W   = 8
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          srst,
    axi_crossbar_wch_scheduler_if.slave   bus
);

    sch_state_t             state;
    sch_state_t             state_next;
    logic                   push;
    logic                   pop;
    logic [MST_IDX_W-1:0]   aw_idx;
    logic                   aw_onehot;
    logic [MST_IDX_W-1:0]   head_idx;
    logic                   full;
    logic                   empty;
    logic [FIFO_DEPTH_W:0]  count;
    logic [BEAT_CNT_W-1:0]  beat_cnt;
    logic                   err;
    logic [MST_NB-1:0]      grant;

    assign aw_idx    = MST_IDX_W'(onehot_to_idx(MST_MAX'(bus.i_aw_grant)));
    assign aw_onehot = is_onehot(MST_MAX'(bus.i_aw_grant));
    // Allow depends on registered fullness only, so a pop never frees a slot
    // for an AW in the same cycle.
    assign push      = bus.i_aw_hs && !full;
    assign pop       = (state == SCH_BURST) && bus.i_w_hs && bus.i_wlast;

    axi_crossbar_order_fifo #(
        .DATA_W  (MST_IDX_W),
        .DEPTH_W (FIFO_DEPTH_W)
    ) u_order_fifo (
        .clk   (aclk),
        .rst_n (aresetn),
        .clr   (srst),
        .push  (push),
        .pop   (pop),
        .din   (aw_idx),
        .head  (head_idx),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Scheduler state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)  state <= SCH_IDLE;
        else if (srst) state <= SCH_IDLE;
        else           state <= state_next;
    end

    // Next state: leave BURST only when the last queued burst pops without a refill.
    always_comb begin
        state_next = state;
        case (state)
            SCH_IDLE:  if (push) state_next = SCH_BURST;
            SCH_BURST: if (pop && !push && (count == (FIFO_DEPTH_W+1)'(1))) state_next = SCH_IDLE;
            default:   state_next = SCH_IDLE;
        endcase
    end

    // Beat counter for the head burst, saturating, cleared on WLAST.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt <= '0;
        end else if (srst) begin
            beat_cnt <= '0;
        end else if ((state == SCH_BURST) && bus.i_w_hs) begin
            if (bus.i_wlast)         beat_cnt <= '0;
            else if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Sticky protocol error: AW while full, malformed AW grant, W beat while idle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err <= 1'b0;
        end else if (srst) begin
            err <= 1'b0;
        end else if ((bus.i_aw_hs && full) || (push && !aw_onehot) ||
                     (bus.i_w_hs && (state == SCH_IDLE))) begin
            err <= 1'b1;
        end
    end

    assign grant             = empty ? '0 : MST_NB'(idx_to_onehot(MST_MAX_IDX_W'(head_idx)));
    assign bus.o_w_grant     = grant;
    assign bus.o_w_active    = |grant;
    assign bus.o_aw_allow    = !full;
    assign bus.o_beat_cnt    = beat_cnt;
    assign bus.o_outstanding = count;
    assign bus.o_err         = err;

endmodule
